// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between the fetch stage
//   (instruction reads) and the memory stage (loads/stores). Only one
//   transaction is outstanding at a time. Data requests win arbitration
//   unless fetch has lost STARVE_LIMIT consecutive arbitrations.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   if_req_i/if_addr_i        fetch read request and address (held until gnt)
//   if_gnt_o                  fetch request accepted (pulse)
//   if_rvalid_o/if_rdata_o    fetched instruction (pulse, data 0 otherwise)
//   dm_req_i/dm_we_i          data request, 1 = store / 0 = load
//   dm_addr_i/dm_wdata_i      data address / store data
//   dm_byte_en_i              store/load byte enables
//   dm_gnt_o                  data request accepted (pulse)
//   dm_rvalid_o/dm_rdata_o    load data or store ack (pulse, data 0 otherwise)
//   mem_req_o/mem_we_o        memory request / write enable
//   mem_addr_o/mem_wdata_o    memory address / write data
//   mem_byte_en_o             memory byte enables (all ones for fetch)
//   mem_ready_i               memory accepts the request this cycle
//   mem_rvalid_i/mem_rdata_i  memory response (reads and writes)
//   busy_o                    a transaction is in flight

module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [DATA_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [DATA_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  input  logic [3:0]            dm_byte_en_i,
  output logic                  dm_gnt_o,
  output logic                  dm_rvalid_o,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_byte_en_o,
  input  logic                  mem_ready_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]            state_q,   state_d;
  logic [3:0]            starve_q,  starve_d;
  logic                  owner_q,   owner_d;   // 0 = fetch, 1 = data
  logic [DATA_WIDTH-1:0] addr_q,    addr_d;
  logic                  we_q,      we_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [3:0]            be_q,      be_d;

  logic fetch_win;
  logic if_gnt;
  logic dm_gnt;
  logic rsp;

  // Fetch wins when alone, or when it has been starved long enough.
  assign fetch_win = if_req_i & (~dm_req_i | (starve_q == LIMIT));

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    if_gnt   = 1'b0;
    dm_gnt   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!if_req_i) begin
          starve_d = '0;
        end
        if (fetch_win) begin
          if_gnt   = 1'b1;
          owner_d  = 1'b0;
          addr_d   = if_addr_i;
          we_d     = 1'b0;
          wdata_d  = '0;
          be_d     = '1;
          starve_d = '0;
          state_d  = ISSUE;
        end else if (dm_req_i) begin
          dm_gnt   = 1'b1;
          owner_d  = 1'b1;
          addr_d   = dm_addr_i;
          we_d     = dm_we_i;
          wdata_d  = dm_wdata_i;
          be_d     = dm_byte_en_i;
          if (if_req_i && (starve_q < LIMIT)) begin
            starve_d = starve_q + 4'd1;
          end
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
    end
  end

  // Grants and responses are masked during reset so the cycle carrying
  // rst never reports a handshake that the state update then discards.
  assign if_gnt_o = if_gnt & ~rst;
  assign dm_gnt_o = dm_gnt & ~rst;

  assign rsp         = (state_q == WAIT) & mem_rvalid_i & ~rst;
  assign if_rvalid_o = rsp & ~owner_q;
  assign dm_rvalid_o = rsp &  owner_q;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;

  assign mem_req_o     = (state_q == ISSUE);
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign mem_byte_en_o = be_q;

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected memory issues and
// responses are queued at grant time from the driven request fields and
// compared when the DUT issues to / returns from the memory model.
module tb_mem_port_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req_i = 1'b0;
  logic [DW-1:0] if_addr_i = '0;
  logic          if_gnt_o, if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          dm_req_i = 1'b0, dm_we_i = 1'b0;
  logic [DW-1:0] dm_addr_i = '0, dm_wdata_i = '0;
  logic [3:0]    dm_byte_en_i = '0;
  logic          dm_gnt_o, dm_rvalid_o;
  logic [DW-1:0] dm_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [DW-1:0] mem_addr_o, mem_wdata_o;
  logic [3:0]    mem_byte_en_o;
  logic          mem_ready_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          busy_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_byte_en_i(dm_byte_en_i), .dm_gnt_o(dm_gnt_o),
    .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_byte_en_o(mem_byte_en_o),
    .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  typedef struct {
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    be;
  } iss_t;

  typedef struct {
    logic          owner;
    logic [DW-1:0] rdata;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  int   stall_cfg = 0;
  int   lat_cfg   = 1;
  logic stray_rv  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0000_0513;
    return (a ^ 32'h5A5A_0000) + 32'h77;
  endfunction

  // Memory model: stall_cfg cycles of backpressure, response lat_cfg
  // cycles after acceptance; drives 2 time units after each rising edge.
  int          stall_left = 0;
  int          wait_left  = 0;
  logic        pending    = 1'b0;
  logic [31:0] lat_addr   = '0;

  always @(posedge clk) begin
    if (mem_req_o && mem_ready_i && !rst) begin
      pending   = 1'b1;
      wait_left = lat_cfg;
      lat_addr  = mem_addr_o;
    end
    #2;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'hBAD0_BAD0;
    if (pending) begin
      if (wait_left <= 1) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_word(lat_addr);
        pending      = 1'b0;
      end else begin
        wait_left--;
      end
    end else if (stray_rv) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h1234_5678;
    end
    if (mem_req_o) begin
      if (stall_left > 0) begin
        mem_ready_i = 1'b0;
        stall_left--;
      end else begin
        mem_ready_i = 1'b1;
      end
    end else begin
      mem_ready_i = 1'b0;
      stall_left  = stall_cfg;
    end
  end

  // Monitor: pops the scoreboard on memory acceptance and on responses.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_gnt_o || dm_gnt_o) begin
        check_eq("gnt_while_busy", busy_o, 0);
      end
      if (mem_req_o && mem_ready_i) begin
        if (iss_q.size() == 0) begin
          check_eq("iss_unexpected", iss_q.size(), 1);
        end else begin
          iss_t e;
          e = iss_q.pop_front();
          check_eq("iss_addr",  mem_addr_o,    e.addr);
          check_eq("iss_we",    mem_we_o,      e.we);
          check_eq("iss_wdata", mem_wdata_o,   e.wdata);
          check_eq("iss_be",    mem_byte_en_o, e.be);
        end
      end
      if (if_rvalid_o || dm_rvalid_o) begin
        if (rsp_q.size() == 0) begin
          check_eq("rsp_unexpected", rsp_q.size(), 1);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          check_eq("rsp_if_v",  if_rvalid_o, !r.owner);
          check_eq("rsp_dm_v",  dm_rvalid_o, r.owner);
          check_eq("rsp_data",  r.owner ? dm_rdata_o : if_rdata_o, r.rdata);
          check_eq("rsp_other", r.owner ? if_rdata_o : dm_rdata_o, 0);
        end
      end else if (mem_rvalid_i) begin
        check_eq("noresp_if_rdata", if_rdata_o, 0);
        check_eq("noresp_dm_rdata", dm_rdata_o, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic await_grant(input logic exp_dm, input string tag);
    int   n   = 0;
    logic got = 1'b0;
    while (n < 60 && !got) begin
      @(negedge clk);
      if (if_gnt_o || dm_gnt_o) got = 1'b1;
      else n++;
    end
    check_eq({tag, "_seen"}, got, 1);
    if (got) begin
      check_eq({tag, "_who"}, dm_gnt_o, exp_dm);
      check_eq({tag, "_excl"}, if_gnt_o & dm_gnt_o, 0);
      if (exp_dm) begin
        iss_q.push_back('{dm_we_i, dm_addr_i, dm_wdata_i, dm_byte_en_i});
        rsp_q.push_back('{1'b1, mem_word(dm_addr_i)});
      end else begin
        iss_q.push_back('{1'b0, if_addr_i, 32'h0, 4'hF});
        rsp_q.push_back('{1'b0, mem_word(if_addr_i)});
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (n < 80 && (busy_o || rsp_q.size() != 0)) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_idle"}, busy_o, 0);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_busy"},   busy_o, 0);
    check_eq({tag, "_if_gnt"}, if_gnt_o, 0);
    check_eq({tag, "_dm_gnt"}, dm_gnt_o, 0);
    check_eq({tag, "_if_rv"},  if_rvalid_o, 0);
    check_eq({tag, "_dm_rv"},  dm_rvalid_o, 0);
    check_eq({tag, "_if_rd"},  if_rdata_o, 0);
    check_eq({tag, "_dm_rd"},  dm_rdata_o, 0);
    check_eq({tag, "_mreq"},   mem_req_o, 0);
    check_eq({tag, "_mwe"},    mem_we_o, 0);
    check_eq({tag, "_maddr"},  mem_addr_o, 0);
    check_eq({tag, "_mwdata"}, mem_wdata_o, 0);
    check_eq({tag, "_mbe"},    mem_byte_en_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int nreq;

    // Reset state
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    tick();
    rst = 1'b0;

    // Single fetch with minimum turnaround
    tick();
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0010;
    await_grant(1'b0, "f1");
    tick();
    if_req_i = 1'b0;
    @(negedge clk);
    check_eq("f1_c1_mreq", mem_req_o, 1);
    check_eq("f1_c1_addr", mem_addr_o, 32'h10);
    check_eq("f1_c1_be",   mem_byte_en_o, 4'hF);
    check_eq("f1_c1_we",   mem_we_o, 0);
    @(negedge clk);
    check_eq("f1_c2_rv",   if_rvalid_o, 1);
    check_eq("f1_c2_rd",   if_rdata_o, 32'h0000_0513);
    @(negedge clk);
    check_eq("f1_c3_busy", busy_o, 0);
    wait_idle("f1");

    // Simultaneous requests: data first, then fetch
    tick();
    if_req_i     = 1'b1;
    if_addr_i    = 32'h0000_0020;
    dm_req_i     = 1'b1;
    dm_we_i      = 1'b1;
    dm_addr_i    = 32'h0000_0100;
    dm_wdata_i   = 32'hDEAD_BEEF;
    dm_byte_en_i = 4'b0011;
    await_grant(1'b1, "sim_d");
    tick();
    dm_req_i   = 1'b0;
    dm_addr_i  = 32'h0000_0104;
    dm_wdata_i = 32'h1111_1111;
    await_grant(1'b0, "sim_f");
    tick();
    if_req_i = 1'b0;
    wait_idle("sim");

    // Starvation guard: D D D D F D with both held high
    tick();
    if_req_i     = 1'b1;
    if_addr_i    = 32'h0000_0300;
    dm_req_i     = 1'b1;
    dm_we_i      = 1'b0;
    dm_addr_i    = 32'h0000_0400;
    dm_byte_en_i = 4'hF;
    for (int i = 0; i < 6; i++) begin
      logic exp_dm;
      exp_dm = (i != 4);
      await_grant(exp_dm, $sformatf("stv%0d", i));
      tick();
      if (exp_dm) dm_addr_i = dm_addr_i + 32'd4;
      else        if_addr_i = if_addr_i + 32'd4;
    end
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
    wait_idle("stv");

    // Backpressure: address latched, request held, no grant while busy
    stall_cfg = 3;
    tick();
    dm_req_i     = 1'b1;
    dm_we_i      = 1'b0;
    dm_addr_i    = 32'h0000_0200;
    dm_byte_en_i = 4'b1100;
    await_grant(1'b1, "bp");
    tick();
    dm_req_i  = 1'b0;
    dm_addr_i = 32'h0000_0999;
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0044;
    nreq = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req_o) begin
        nreq++;
        check_eq("bp_addr", mem_addr_o, 32'h200);
      end else if (nreq > 0) begin
        break;
      end
    end
    check_eq("bp_len", nreq, 4);
    await_grant(1'b0, "bp_f");
    tick();
    if_req_i  = 1'b0;
    stall_cfg = 0;
    wait_idle("bp");

    // Reset while waiting for the response; stale response is dropped
    lat_cfg = 2;
    tick();
    dm_req_i     = 1'b1;
    dm_we_i      = 1'b1;
    dm_addr_i    = 32'h0000_0500;
    dm_wdata_i   = 32'hCAFE_F00D;
    dm_byte_en_i = 4'b0001;
    await_grant(1'b1, "rs");
    tick();
    dm_req_i = 1'b0;
    tick();
    @(negedge clk);
    check_eq("rs_wait_busy", busy_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_q.delete();
    @(negedge clk);
    check_quiet("rs");
    lat_cfg = 1;
    tick();
    @(negedge clk);
    check_eq("rs_after_busy", busy_o, 0);

    // Stray response in IDLE
    tick();
    stray_rv = 1'b1;
    @(negedge clk);
    check_eq("stray_if_rv", if_rvalid_o, 0);
    check_eq("stray_dm_rv", dm_rvalid_o, 0);
    check_eq("stray_busy",  busy_o, 0);
    tick();
    stray_rv = 1'b0;
    @(negedge clk);
    check_eq("stray_busy2", busy_o, 0);

    check_eq("iss_left", iss_q.size(), 0);
    check_eq("rsp_left", rsp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares a single-ported unified memory between the fetch stage (instruction reads) and the memory stage (loads/stores) of the 5-stage RV32I pipeline.
- Allows exactly one outstanding transaction at a time.
- Data requests have priority (older instruction), with a starvation guard for fetch.
- Pipeline stall logic treats a missing grant or response as a stall condition.

Parameters:
- DATA_WIDTH, 32, width of address and data buses.
- STARVE_LIMIT, 4, number of consecutive fetch losses after which fetch wins the next arbitration (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req_i  in  1  fetch read request; held until if_gnt_o.
- if_addr_i  in  DATA_WIDTH  fetch address.
- if_gnt_o  out  1  fetch request accepted (one-cycle pulse).
- if_rvalid_o  out  1  fetch read data valid (one-cycle pulse).
- if_rdata_o  out  DATA_WIDTH  fetched instruction.
- dm_req_i  in  1  data request; held until dm_gnt_o.
- dm_we_i  in  1  1 = store, 0 = load.
- dm_addr_i  in  DATA_WIDTH  data address.
- dm_wdata_i  in  DATA_WIDTH  store data.
- dm_byte_en_i  in  4  byte enables.
- dm_gnt_o  out  1  data request accepted (pulse).
- dm_rvalid_o  out  1  load data / store acknowledge (pulse).
- dm_rdata_o  out  DATA_WIDTH  load data.
- mem_req_o  out  1  request to memory.
- mem_we_o  out  1  write enable to memory.
- mem_addr_o  out  DATA_WIDTH  memory address.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_byte_en_o  out  4  memory byte enables; 4'b1111 for fetch.
- mem_ready_i  in  1  memory accepts request this cycle.
- mem_rvalid_i  in  1  memory response valid; returned for both reads and writes.
- mem_rdata_i  in  DATA_WIDTH  memory read data.
- busy_o  out  1  a transaction is in flight (state != IDLE).

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, starve_cnt=0, owner=0.
  - All latched request fields cleared to 0.
  - All outputs 0.
  - Any in-flight transaction is abandoned; mem_rvalid_i is ignored until a new request is issued.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - No request: stay in IDLE; all gnt, rvalid and mem_req_o are 0.
  - Winner selection:
    - Only one requester active: it wins.
    - Both requesting and starve_cnt == STARVE_LIMIT: fetch wins.
    - Otherwise, both requesting: data wins.
  - Winner's gnt_o is asserted combinationally in the same cycle.
  - The winner's addr/we/wdata/byte_en are registered (fetch: we=0, byte_en=4'b1111, wdata=0).
  - owner is registered (0 = fetch, 1 = data); next state is ISSUE.
- ISSUE:
  - mem_req_o=1; mem_* driven from the registered fields only (stable until accepted).
  - mem_ready_i=1: go to WAIT. Otherwise stay in ISSUE, holding all mem_* values.
- WAIT:
  - mem_req_o=0.
  - On mem_rvalid_i=1, the owner's rvalid_o=1 (combinational, same cycle) and its rdata_o = mem_rdata_i; next state is IDLE.
  - The non-owner's rvalid_o and rdata_o stay 0.
- mem_rvalid_i in IDLE or ISSUE is ignored. Responses arriving in the same cycle as mem_ready_i are not supported; memory latency is at least 1 cycle after acceptance.
- Minimum turnaround: req in cycle 0 → gnt cycle 0, mem_req_o cycle 1, rvalid cycle 2, next grant possible cycle 3.
- rdata_o outputs are 0 whenever the corresponding rvalid_o is 0.
- starve_cnt update, evaluated only on IDLE grant cycles:
  - Data wins while if_req_i=1: increment, saturating at STARVE_LIMIT.
  - Fetch wins: clear to 0.
  - In IDLE with if_req_i=0: clear to 0.
- Requests arriving while busy_o=1 are not granted; requesters hold them.
- Write data/addr changes on request inputs after grant have no effect on the issued transaction.

Test Plan:
- Single fetch: if_req_i=1, if_addr_i=0x0000_0010; memory ready immediately, rvalid 1 cycle later with rdata=0x0000_0513 → if_gnt_o cycle 0, mem_req_o cycle 1 with addr 0x10, byte_en 4'b1111; if_rvalid_o cycle 2, rdata 0x0000_0513; busy_o falls cycle 3.
- Simultaneous requests: both asserted at cycle 0, dm_we_i=1, addr 0x100, wdata 0xDEADBEEF, byte_en 4'b0011 → dm_gnt_o cycle 0; mem_we_o=1 with exact fields; after ack, fetch granted at the next IDLE.
- Starvation: STARVE_LIMIT=4; dm_req_i and if_req_i held high continuously → four data grants, then fifth grant goes to fetch, then starve_cnt=0 and data wins again.
- Backpressure: mem_ready_i low for 3 cycles in ISSUE while dm_addr_i changes after grant → mem_req_o held 3+1 cycles with original address; no second grant while busy_o=1.
- Reset mid-operation: assert rst in WAIT before mem_rvalid_i → next cycle all outputs 0, state IDLE; a stale mem_rvalid_i=1 the following cycle produces no rvalid_o.
- Stray response: mem_rvalid_i=1 in IDLE with no request → if_rvalid_o=dm_rvalid_o=0, no state change.
